// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, frames 11-bit device-to-host
// bytes and decodes make/break (and E0-extended) scan codes into a held-key state.
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 2700,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock27,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyDataOut,
  output logic [1:0] keyPressed,
  output logic       byteValid,
  output logic [7:0] rxByte,
  output logic       frameError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_parity;
  logic [TW-1:0]          r_tmo_cnt;
  logic                   r_ext;
  logic                   r_brk;
  logic                   w_edge;
  logic                   w_data;
  logic                   w_timeout;
  logic                   w_frame_ok;
  logic                   w_frame_bad;

  // Synchroniser stages idle high, matching an idle PS/2 bus, so reset never fakes an edge.
  always_ff @(posedge clock27) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_data    = r_dat_sync[SYNC_STAGES-1];
  // An edge in the same cycle as expiry keeps the frame alive.
  assign w_timeout = (r_state != S_IDLE) && !w_edge && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock27) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      S_IDLE:   if (w_edge && !w_data) w_state_nxt = S_DATA;
      S_DATA:   if (w_edge && (r_bit_cnt == 3'd7)) w_state_nxt = S_PARITY;
      S_PARITY: if (w_edge) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_edge) begin
          w_state_nxt = S_IDLE;
          if (w_data && ((^r_shift) ^ r_parity)) w_frame_ok  = 1'b1;
          else                                   w_frame_bad = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clock27) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_parity   <= 1'b0;
      r_tmo_cnt  <= '0;
      rxByte     <= '0;
      byteValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      byteValid  <= w_frame_ok;
      frameError <= w_frame_bad;
      if (w_edge || (r_state == S_IDLE))       r_tmo_cnt <= '0;
      else if (r_tmo_cnt != TW'(TIMEOUT_CYCLES)) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_edge && (r_state == S_DATA)) begin
        r_shift   <= {w_data, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_edge && (r_state == S_PARITY)) r_parity <= w_data;
      if (w_frame_ok) rxByte <= r_shift;
    end
  end

  // Decoder consumes the completed byte in the same cycle it is latched into rxByte.
  always_ff @(posedge clock27) begin
    if (!reset_n) begin
      keyDataOut <= '0;
      keyPressed <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
    end else if (w_frame_bad) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_frame_ok) begin
      case (r_shift)
        8'hE0: r_ext <= 1'b1;
        8'hF0: r_brk <= 1'b1;
        default: begin
          if (!r_brk) begin
            keyDataOut <= r_shift;
            keyPressed <= {r_ext, 1'b1};
          end else if ((r_shift == keyDataOut) && (keyPressed[1] == r_ext)) begin
            keyPressed <= 2'b00;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: bit-bangs PS/2 frames and checks pulses and key state.
module tb_ps2_key_receiver;

  logic       clock27 = 1'b0;
  logic       reset_n = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyDataOut;
  logic [1:0] keyPressed;
  logic       byteValid;
  logic [7:0] rxByte;
  logic       frameError;

  int n_cmp = 0;
  int n_bad = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] last_rx = 8'h00;

  ps2_key_receiver #(.TIMEOUT_CYCLES(2700), .SYNC_STAGES(2)) dut (
    .clock27    (clock27),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keyDataOut (keyDataOut),
    .keyPressed (keyPressed),
    .byteValid  (byteValid),
    .rxByte     (rxByte),
    .frameError (frameError)
  );

  always #5 clock27 = ~clock27;

  // Counts high cycles, so a pulse wider than one cycle shows up as an extra count.
  always @(negedge clock27) begin
    if (byteValid === 1'b1) begin
      bv_cnt  = bv_cnt + 1;
      last_rx = rxByte;
    end
    if (frameError === 1'b1) fe_cnt = fe_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock27);
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_cyc(4);
      ps2_clk = 1'b0;
      wait_cyc(8);
      ps2_clk = 1'b1;
      wait_cyc(4);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    send_bits(f, 11);
    wait_cyc(20);
  endtask

  task automatic test_reset;
    @(negedge clock27) reset_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(5);
    n_cmp++; if (keyDataOut !== 8'h00) begin n_bad++; $display("FAIL reset_key: got %h exp 00", keyDataOut); end
    n_cmp++; if (keyPressed !== 2'b00) begin n_bad++; $display("FAIL reset_pressed: got %b exp 00", keyPressed); end
    n_cmp++; if (rxByte !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h exp 00", rxByte); end
    n_cmp++; if ({byteValid, frameError} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b exp 00", {byteValid, frameError}); end
  endtask

  task automatic test_make;
    int bv0, fe0;
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_byte(8'h1C, 1'b0);
    n_cmp++; if (bv_cnt - bv0 !== 1) begin n_bad++; $display("FAIL make_bv_count: got %0d exp 1", bv_cnt - bv0); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL make_fe_count: got %0d exp 0", fe_cnt - fe0); end
    n_cmp++; if (last_rx !== 8'h1C) begin n_bad++; $display("FAIL make_rx_pulse: got %h exp 1C", last_rx); end
    n_cmp++; if (rxByte !== 8'h1C) begin n_bad++; $display("FAIL make_rx_hold: got %h exp 1C", rxByte); end
    n_cmp++; if (keyDataOut !== 8'h1C) begin n_bad++; $display("FAIL make_key: got %h exp 1C", keyDataOut); end
    n_cmp++; if (keyPressed !== 2'b01) begin n_bad++; $display("FAIL make_pressed: got %b exp 01", keyPressed); end
  endtask

  task automatic test_break;
    int bv0;
    bv0 = bv_cnt;
    send_byte(8'hF0, 1'b0);
    n_cmp++; if (keyPressed !== 2'b01) begin n_bad++; $display("FAIL brk_prefix_pressed: got %b exp 01", keyPressed); end
    send_byte(8'h1C, 1'b0);
    n_cmp++; if (bv_cnt - bv0 !== 2) begin n_bad++; $display("FAIL brk_bv_count: got %0d exp 2", bv_cnt - bv0); end
    n_cmp++; if (keyPressed !== 2'b00) begin n_bad++; $display("FAIL brk_pressed: got %b exp 00", keyPressed); end
    n_cmp++; if (keyDataOut !== 8'h1C) begin n_bad++; $display("FAIL brk_key: got %h exp 1C", keyDataOut); end
  endtask

  task automatic test_extended;
    send_byte(8'hE0, 1'b0);
    n_cmp++; if (keyPressed !== 2'b00) begin n_bad++; $display("FAIL ext_prefix_pressed: got %b exp 00", keyPressed); end
    send_byte(8'h75, 1'b0);
    n_cmp++; if (keyDataOut !== 8'h75) begin n_bad++; $display("FAIL ext_key: got %h exp 75", keyDataOut); end
    n_cmp++; if (keyPressed !== 2'b11) begin n_bad++; $display("FAIL ext_pressed: got %b exp 11", keyPressed); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_cmp++; if (keyPressed !== 2'b00) begin n_bad++; $display("FAIL ext_release: got %b exp 00", keyPressed); end
    n_cmp++; if (keyDataOut !== 8'h75) begin n_bad++; $display("FAIL ext_release_key: got %h exp 75", keyDataOut); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    n_cmp++; if (keyPressed !== 2'b11) begin n_bad++; $display("FAIL ext_plain_break: got %b exp 11", keyPressed); end
  endtask

  task automatic test_parity_error;
    int bv0, fe0;
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_byte(8'h1C, 1'b1);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL par_fe_count: got %0d exp 1", fe_cnt - fe0); end
    n_cmp++; if (bv_cnt - bv0 !== 0) begin n_bad++; $display("FAIL par_bv_count: got %0d exp 0", bv_cnt - bv0); end
    n_cmp++; if ({keyDataOut, keyPressed} !== {8'h75, 2'b11}) begin n_bad++; $display("FAIL par_outputs: got %h/%b exp 75/11", keyDataOut, keyPressed); end
    n_cmp++; if (rxByte !== 8'h75) begin n_bad++; $display("FAIL par_rx_hold: got %h exp 75", rxByte); end
  endtask

  task automatic test_timeout;
    int fe0;
    logic [10:0] f;
    fe0 = fe_cnt;
    f = {1'b1, 1'b0, 8'hA5, 1'b0};
    send_bits(f, 6);
    wait_cyc(2600);
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL tmo_early: got %0d exp 0", fe_cnt - fe0); end
    wait_cyc(200);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL tmo_fe_count: got %0d exp 1", fe_cnt - fe0); end
    send_byte(8'h32, 1'b0);
    n_cmp++; if (keyDataOut !== 8'h32) begin n_bad++; $display("FAIL tmo_next_key: got %h exp 32", keyDataOut); end
    n_cmp++; if (keyPressed !== 2'b01) begin n_bad++; $display("FAIL tmo_next_pressed: got %b exp 01", keyPressed); end
  endtask

  task automatic test_mid_reset;
    int bv0, fe0;
    logic [10:0] f;
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    send_bits(f, 5);
    bv0 = bv_cnt; fe0 = fe_cnt;
    @(negedge clock27) reset_n = 1'b0;
    @(negedge clock27) reset_n = 1'b1;
    n_cmp++; if ({keyDataOut, keyPressed, rxByte} !== 18'h0) begin n_bad++; $display("FAIL mrst_outputs: got %h/%b/%h exp 00/00/00", keyDataOut, keyPressed, rxByte); end
    wait_cyc(3000);
    n_cmp++; if ((bv_cnt - bv0) + (fe_cnt - fe0) !== 0) begin n_bad++; $display("FAIL mrst_pulses: got %0d exp 0", (bv_cnt - bv0) + (fe_cnt - fe0)); end
    send_byte(8'h1C, 1'b0);
    n_cmp++; if ({keyDataOut, keyPressed} !== {8'h1C, 2'b01}) begin n_bad++; $display("FAIL mrst_decode: got %h/%b exp 1C/01", keyDataOut, keyPressed); end
  endtask

  task automatic test_back_to_back;
    int bv0;
    bv0 = bv_cnt;
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 11);
    send_bits({1'b1, ~^8'h4B, 8'h4B, 1'b0}, 11);
    wait_cyc(20);
    n_cmp++; if (bv_cnt - bv0 !== 2) begin n_bad++; $display("FAIL b2b_bv_count: got %0d exp 2", bv_cnt - bv0); end
    n_cmp++; if ({keyDataOut, keyPressed} !== {8'h4B, 2'b01}) begin n_bad++; $display("FAIL b2b_last_key: got %h/%b exp 4B/01", keyDataOut, keyPressed); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    n_cmp++; if (keyPressed !== 2'b01) begin n_bad++; $display("FAIL b2b_stale_break: got %b exp 01", keyPressed); end
  endtask

  initial begin
    wait_cyc(2);
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_error();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
